// File: rtl/alu_share_arb.sv
// Shares one combinational ALU between two valid/ready requesters: arbitrate,
// register the winner into a single execute stage, return the result through per-requester slots.

module alu (
    input  logic [31:0] i_op1,
    input  logic [31:0] i_op2,
    input  logic [3:0]  i_ctrl,
    output logic [31:0] o_result,
    output logic        o_zero
);
    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_XOR  = 4'b0100;
    localparam logic [3:0] ALU_SLL  = 4'b0101;
    localparam logic [3:0] ALU_SRL  = 4'b0110;
    localparam logic [3:0] ALU_SRA  = 4'b0111;
    localparam logic [3:0] ALU_SLT  = 4'b1000;
    localparam logic [3:0] ALU_SLTU = 4'b1001;

    logic [4:0] shamt;

    assign shamt = i_op2[4:0];

    // Codes 1010..1111 are unassigned and deliberately produce zero.
    always_comb begin
        o_result = 32'd0;
        case (i_ctrl)
            ALU_ADD:  o_result = i_op1 + i_op2;
            ALU_SUB:  o_result = i_op1 - i_op2;
            ALU_AND:  o_result = i_op1 & i_op2;
            ALU_OR:   o_result = i_op1 | i_op2;
            ALU_XOR:  o_result = i_op1 ^ i_op2;
            ALU_SLL:  o_result = i_op1 << shamt;
            ALU_SRL:  o_result = i_op1 >> shamt;
            ALU_SRA:  o_result = $unsigned($signed(i_op1) >>> shamt);
            ALU_SLT:  o_result = {31'd0, $signed(i_op1) < $signed(i_op2)};
            ALU_SLTU: o_result = {31'd0, i_op1 < i_op2};
            default:  o_result = 32'd0;
        endcase
    end

    assign o_zero = (o_result == 32'd0);
endmodule

module alu_share_arb #(
    parameter int unsigned RR = 1
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_req0_valid,
    input  logic [31:0] i_req0_op1,
    input  logic [31:0] i_req0_op2,
    input  logic [3:0]  i_req0_ctrl,
    output logic        o_req0_ready,
    output logic        o_rsp0_valid,
    input  logic        i_rsp0_ready,
    output logic [31:0] o_rsp0_result,
    output logic        o_rsp0_zero,
    input  logic        i_req1_valid,
    input  logic [31:0] i_req1_op1,
    input  logic [31:0] i_req1_op2,
    input  logic [3:0]  i_req1_ctrl,
    output logic        o_req1_ready,
    output logic        o_rsp1_valid,
    input  logic        i_rsp1_ready,
    output logic [31:0] o_rsp1_result,
    output logic        o_rsp1_zero
);
    logic [1:0]        req_valid;
    logic [1:0][31:0]  req_op1;
    logic [1:0][31:0]  req_op2;
    logic [1:0][3:0]   req_ctrl;
    logic [1:0]        rsp_ready;

    logic [1:0]        eligible;
    logic [1:0]        grant;
    logic              grant_id;

    logic              stg_valid_reg;
    logic              stg_id_reg;
    logic [31:0]       stg_op1_reg;
    logic [31:0]       stg_op2_reg;
    logic [3:0]        stg_ctrl_reg;
    logic              last_reg;

    logic [1:0]        rsp_valid_reg;
    logic [1:0][31:0]  rsp_result_reg;
    logic [1:0]        rsp_zero_reg;

    logic [31:0]       alu_result;
    logic              alu_zero;

    assign req_valid = {i_req1_valid, i_req0_valid};
    assign req_op1   = {i_req1_op1, i_req0_op1};
    assign req_op2   = {i_req1_op2, i_req0_op2};
    assign req_ctrl  = {i_req1_ctrl, i_req0_ctrl};
    assign rsp_ready = {i_rsp1_ready, i_rsp0_ready};

    // One op in flight per requester: a full slot or a staged op blocks new issue.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_elig
            assign eligible[gi] = req_valid[gi] && !rsp_valid_reg[gi]
                                  && !(stg_valid_reg && (stg_id_reg == 1'(gi)));
        end
    endgenerate

    always_comb begin
        grant = 2'b00;
        if (!i_rst) begin
            if (eligible == 2'b11) begin
                if ((RR != 0) && (last_reg == 1'b0)) begin
                    grant = 2'b10;
                end else begin
                    grant = 2'b01;
                end
            end else begin
                grant = eligible;
            end
        end
    end

    assign grant_id     = grant[1];
    assign o_req0_ready = grant[0];
    assign o_req1_ready = grant[1];

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            stg_valid_reg <= 1'b0;
            stg_id_reg    <= 1'b0;
            stg_op1_reg   <= 32'd0;
            stg_op2_reg   <= 32'd0;
            stg_ctrl_reg  <= 4'd0;
            last_reg      <= 1'b1;
        end else begin
            stg_valid_reg <= |grant;
            if (|grant) begin
                stg_id_reg   <= grant_id;
                stg_op1_reg  <= req_op1[grant_id];
                stg_op2_reg  <= req_op2[grant_id];
                stg_ctrl_reg <= req_ctrl[grant_id];
                last_reg     <= grant_id;
            end
        end
    end

    alu u_alu (
        .i_op1    (stg_op1_reg),
        .i_op2    (stg_op2_reg),
        .i_ctrl   (stg_ctrl_reg),
        .o_result (alu_result),
        .o_zero   (alu_zero)
    );

    // A write and a drain never hit the same slot on one edge, so their order is moot.
    generate
        for (genvar gi = 0; gi < 2; gi++) begin : g_slot
            always_ff @(posedge i_clk or posedge i_rst) begin
                if (i_rst) begin
                    rsp_valid_reg[gi]  <= 1'b0;
                    rsp_result_reg[gi] <= 32'd0;
                    rsp_zero_reg[gi]   <= 1'b0;
                end else if (stg_valid_reg && (stg_id_reg == 1'(gi))) begin
                    rsp_valid_reg[gi]  <= 1'b1;
                    rsp_result_reg[gi] <= alu_result;
                    rsp_zero_reg[gi]   <= alu_zero;
                end else if (rsp_valid_reg[gi] && rsp_ready[gi]) begin
                    rsp_valid_reg[gi]  <= 1'b0;
                end
            end
        end
    endgenerate

    assign o_rsp0_valid  = rsp_valid_reg[0];
    assign o_rsp0_result = rsp_result_reg[0];
    assign o_rsp0_zero   = rsp_zero_reg[0];
    assign o_rsp1_valid  = rsp_valid_reg[1];
    assign o_rsp1_result = rsp_result_reg[1];
    assign o_rsp1_zero   = rsp_zero_reg[1];
endmodule

// File: tb/tb_alu_share_arb.sv
// Directed bench for alu_share_arb: a round-robin and a fixed-priority instance share stimulus.

module tb_alu_share_arb;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic [1:0]       req_valid;
    logic [1:0]       rsp_ready;
    logic [1:0][31:0] op1;
    logic [1:0][31:0] op2;
    logic [1:0][3:0]  ctrl;

    wire [1:0]        req_ready, rsp_valid, rsp_zero;
    wire [1:0][31:0]  rsp_result;
    wire [1:0]        fp_req_ready, fp_rsp_valid, fp_rsp_zero;
    wire [1:0][31:0]  fp_rsp_result;

    int n_checks = 0;
    int n_fail   = 0;

    logic [1:0]  fp_tab [8];
    logic [1:0]  rr_tab [8];
    logic [31:0] vec_res [16];
    logic        vec_zero [16];

    always #5 clk = ~clk;

    alu_share_arb dut (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(req_valid[0]), .i_req0_op1(op1[0]), .i_req0_op2(op2[0]), .i_req0_ctrl(ctrl[0]),
        .o_req0_ready(req_ready[0]), .o_rsp0_valid(rsp_valid[0]), .i_rsp0_ready(rsp_ready[0]),
        .o_rsp0_result(rsp_result[0]), .o_rsp0_zero(rsp_zero[0]),
        .i_req1_valid(req_valid[1]), .i_req1_op1(op1[1]), .i_req1_op2(op2[1]), .i_req1_ctrl(ctrl[1]),
        .o_req1_ready(req_ready[1]), .o_rsp1_valid(rsp_valid[1]), .i_rsp1_ready(rsp_ready[1]),
        .o_rsp1_result(rsp_result[1]), .o_rsp1_zero(rsp_zero[1])
    );

    alu_share_arb #(.RR(0)) dut_fp (
        .i_clk(clk), .i_rst(rst),
        .i_req0_valid(req_valid[0]), .i_req0_op1(op1[0]), .i_req0_op2(op2[0]), .i_req0_ctrl(ctrl[0]),
        .o_req0_ready(fp_req_ready[0]), .o_rsp0_valid(fp_rsp_valid[0]), .i_rsp0_ready(rsp_ready[0]),
        .o_rsp0_result(fp_rsp_result[0]), .o_rsp0_zero(fp_rsp_zero[0]),
        .i_req1_valid(req_valid[1]), .i_req1_op1(op1[1]), .i_req1_op2(op2[1]), .i_req1_ctrl(ctrl[1]),
        .o_req1_ready(fp_req_ready[1]), .o_rsp1_valid(fp_rsp_valid[1]), .i_rsp1_ready(rsp_ready[1]),
        .o_rsp1_result(fp_rsp_result[1]), .o_rsp1_zero(fp_rsp_zero[1])
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%h exp=%h t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // A drain and a stage write must never target the same slot on one edge.
    always @(negedge clk) begin
        if (!rst) begin
            for (int n = 0; n < 2; n++) begin
                chk("drain_write_overlap",
                    {31'd0, dut.stg_valid_reg && (dut.stg_id_reg == n[0])
                            && rsp_valid[n] && rsp_ready[n]}, 32'd0);
            end
        end
    end

    task automatic run_op(input int id, input logic [31:0] a, input logic [31:0] b,
                          input logic [3:0] c, input logic [31:0] er, input logic ez);
        int other;
        other = 1 - id;
        op1[id] = a; op2[id] = b; ctrl[id] = c; req_valid[id] = 1'b1;
        #1;
        chk("mix_ready", {31'd0, req_ready[id]}, 32'd1);
        chk("mix_ready_other", {31'd0, req_ready[other]}, 32'd0);
        tick();
        req_valid[id] = 1'b0;
        chk("mix_rsp_early", {31'd0, rsp_valid[id]}, 32'd0);
        tick();
        chk("mix_rsp_valid", {31'd0, rsp_valid[id]}, 32'd1);
        chk("mix_result", rsp_result[id], er);
        chk("mix_zero", {31'd0, rsp_zero[id]}, {31'd0, ez});
        chk("mix_other_idle", {31'd0, rsp_valid[other]}, 32'd0);
        $display("op id=%0d ctrl=%b a=%h b=%h result=%h zero=%0d", id, c, a, b, rsp_result[id], rsp_zero[id]);
        rsp_ready[id] = 1'b1;
        tick();
        chk("mix_drained", {31'd0, rsp_valid[id]}, 32'd0);
        rsp_ready[id] = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog timeout");
        $fatal(1, "timeout");
    end

    initial begin
        fp_tab = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b01, 2'b10};
        rr_tab = '{2'b01, 2'b10, 2'b00, 2'b01, 2'b00, 2'b00, 2'b10, 2'b00};
        vec_res  = '{32'hFFFFFFF3, 32'hFFFFFFED, 32'h00000000, 32'hFFFFFFF3,
                     32'hFFFFFFF3, 32'hFFFFFF80, 32'h1FFFFFFE, 32'hFFFFFFFE,
                     32'h00000001, 32'h00000000, 32'h00000000, 32'h00000000,
                     32'h00000000, 32'h00000000, 32'h00000000, 32'h00000000};
        vec_zero = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0,
                     1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
        req_valid = 2'b00; rsp_ready = 2'b00;
        op1 = '0; op2 = '0; ctrl = '0;

        // Reset values, then a single ADD 5,7 from requester 0
        #2;
        op1[0] = 32'd5; op2[0] = 32'd7; ctrl[0] = 4'b0000; req_valid[0] = 1'b1;
        #1;
        chk("rst_ready0", {31'd0, req_ready[0]}, 32'd0);
        chk("rst_rsp0_valid", {31'd0, rsp_valid[0]}, 32'd0);
        chk("rst_rsp0_result", rsp_result[0], 32'd0);
        chk("rst_rsp0_zero", {31'd0, rsp_zero[0]}, 32'd0);
        chk("rst_rsp1_valid", {31'd0, rsp_valid[1]}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("t1_ready_pre", {31'd0, req_ready[0]}, 32'd1);
        tick();
        chk("t1_ready_e1", {31'd0, req_ready[0]}, 32'd0);
        chk("t1_rsp_e1", {31'd0, rsp_valid[0]}, 32'd0);
        tick();
        chk("t1_rsp_valid", {31'd0, rsp_valid[0]}, 32'd1);
        chk("t1_result", rsp_result[0], 32'd12);
        chk("t1_zero", {31'd0, rsp_zero[0]}, 32'd0);
        chk("t1_ready_e2", {31'd0, req_ready[0]}, 32'd0);
        $display("t1 add rsp0 result=%0d", rsp_result[0]);
        tick();
        chk("t1_rsp_hold", {31'd0, rsp_valid[0]}, 32'd1);
        chk("t1_ready_e3", {31'd0, req_ready[0]}, 32'd0);
        rsp_ready[0] = 1'b1;
        tick();
        chk("t1_rsp_drained", {31'd0, rsp_valid[0]}, 32'd0);
        chk("t1_ready_again", {31'd0, req_ready[0]}, 32'd1);
        req_valid[0] = 1'b0; rsp_ready[0] = 1'b0;

        // Tie under round-robin from reset
        rst = 1'b1;
        op1[0] = 32'd9; op2[0] = 32'd9; ctrl[0] = 4'b0001;
        op1[1] = 32'd1; op2[1] = 32'd4; ctrl[1] = 4'b0101;
        req_valid = 2'b11;
        #1;
        chk("t2_rst_ready", {30'd0, req_ready}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        #1;
        chk("t2_ready_c0", {30'd0, req_ready}, 32'd1);
        tick();
        chk("t2_ready_c1", {30'd0, req_ready}, 32'd2);
        tick();
        req_valid = 2'b00;
        chk("t2_rsp0_valid", {31'd0, rsp_valid[0]}, 32'd1);
        chk("t2_rsp0_result", rsp_result[0], 32'd0);
        chk("t2_rsp0_zero", {31'd0, rsp_zero[0]}, 32'd1);
        chk("t2_rsp1_not_yet", {31'd0, rsp_valid[1]}, 32'd0);
        tick();
        chk("t2_rsp1_valid", {31'd0, rsp_valid[1]}, 32'd1);
        chk("t2_rsp1_result", rsp_result[1], 32'd16);
        chk("t2_rsp1_zero", {31'd0, rsp_zero[1]}, 32'd0);
        $display("t2 tie rsp0=%h rsp1=%h", rsp_result[0], rsp_result[1]);
        rsp_ready = 2'b11;
        tick();
        chk("t2_drained", {30'd0, rsp_valid}, 32'd0);
        rsp_ready = 2'b00;

        // Back-pressure on rsp0 must not block requester 1
        op1[0] = 32'd3; op2[0] = 32'd4; ctrl[0] = 4'b0000; req_valid[0] = 1'b1;
        #1;
        chk("t3_ready0", {31'd0, req_ready[0]}, 32'd1);
        tick();
        tick();
        chk("t3_rsp0_valid", {31'd0, rsp_valid[0]}, 32'd1);
        chk("t3_rsp0_result", rsp_result[0], 32'd7);
        op1[1] = 32'h80000000; op2[1] = 32'd4; ctrl[1] = 4'b0111; req_valid[1] = 1'b1;
        #1;
        chk("t3_ready1", {31'd0, req_ready[1]}, 32'd1);
        chk("t3_ready0_blocked", {31'd0, req_ready[0]}, 32'd0);
        tick();
        req_valid[1] = 1'b0;
        chk("t3_ready0_blocked2", {31'd0, req_ready[0]}, 32'd0);
        tick();
        chk("t3_rsp1_valid", {31'd0, rsp_valid[1]}, 32'd1);
        chk("t3_rsp1_result", rsp_result[1], 32'hF8000000);
        chk("t3_rsp1_zero", {31'd0, rsp_zero[1]}, 32'd0);
        chk("t3_rsp0_stable", rsp_result[0], 32'd7);
        $display("t3 sra rsp1=%h rsp0 held=%h", rsp_result[1], rsp_result[0]);
        rsp_ready[1] = 1'b1;
        tick();
        chk("t3_rsp1_drained", {31'd0, rsp_valid[1]}, 32'd0);
        chk("t3_rsp0_still", {31'd0, rsp_valid[0]}, 32'd1);
        rsp_ready[1] = 1'b0; rsp_ready[0] = 1'b1;
        #1;
        chk("t3_no_bypass", {31'd0, req_ready[0]}, 32'd0);
        tick();
        chk("t3_rsp0_drained", {31'd0, rsp_valid[0]}, 32'd0);
        chk("t3_ready0_back", {31'd0, req_ready[0]}, 32'd1);
        req_valid = 2'b00; rsp_ready = 2'b00;

        // Fixed priority vs round-robin with both requesters always valid
        rst = 1'b1;
        op1[0] = 32'd1; op2[0] = 32'd1; ctrl[0] = 4'b0000;
        op1[1] = 32'd2; op2[1] = 32'd2; ctrl[1] = 4'b0000;
        req_valid = 2'b11; rsp_ready = 2'b01;
        tick(); tick();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            rsp_ready[1] = (c == 5);
            #1;
            chk("t4_fp_grant", {30'd0, fp_req_ready}, {30'd0, fp_tab[c]});
            if (c <= 6) chk("t4_rr_grant", {30'd0, req_ready}, {30'd0, rr_tab[c]});
            if (c == 2) chk("t4_fp_rsp0", fp_rsp_result[0], 32'd2);
            if (c == 3) chk("t4_fp_rsp1", fp_rsp_result[1], 32'd4);
            $display("t4 cycle=%0d fp_ready=%b rr_ready=%b", c, fp_req_ready, req_ready);
            tick();
        end
        req_valid = 2'b00; rsp_ready = 2'b00;

        // Asynchronous reset with a response pending and an op staged
        rst = 1'b1;
        tick(); tick();
        rst = 1'b0;
        op1[1] = 32'd1; op2[1] = 32'd2; ctrl[1] = 4'b1001; req_valid[1] = 1'b1;
        #1;
        chk("t5_ready1", {31'd0, req_ready[1]}, 32'd1);
        tick();
        req_valid[1] = 1'b0;
        op1[0] = 32'd10; op2[0] = 32'd20; ctrl[0] = 4'b0000; req_valid[0] = 1'b1;
        #1;
        chk("t5_ready0", {31'd0, req_ready[0]}, 32'd1);
        tick();
        req_valid[0] = 1'b0;
        chk("t5_rsp1_valid", {31'd0, rsp_valid[1]}, 32'd1);
        chk("t5_rsp1_result", rsp_result[1], 32'd1);
        #2;
        rst = 1'b1;
        #1;
        chk("t5_rst_rsp1_valid", {31'd0, rsp_valid[1]}, 32'd0);
        chk("t5_rst_rsp1_result", rsp_result[1], 32'd0);
        chk("t5_rst_rsp1_zero", {31'd0, rsp_zero[1]}, 32'd0);
        chk("t5_rst_rsp0_valid", {31'd0, rsp_valid[0]}, 32'd0);
        chk("t5_rst_fp_rsp1", {31'd0, fp_rsp_valid[1]}, 32'd0);
        tick(); tick();
        rst = 1'b0;
        tick(); tick(); tick();
        chk("t5_no_late_rsp", {30'd0, rsp_valid}, 32'd0);
        $display("t5 reset mid-op rsp_valid=%b", rsp_valid);

        // All 16 ctrl codes, alternating requesters
        for (int i = 0; i < 16; i++) begin
            run_op(i % 2, 32'hFFFFFFF0, 32'h00000003, 4'(i), vec_res[i], vec_zero[i]);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
